// File: rtl/fetch_stage.sv
// IF stage of the 16-bit pipelined MIPS core: owns the PC, drives the instruction
// memory address and fills the IF/ID pipeline register (stall, redirect, HALT).
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_instr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [15:0] ifid_pc_q;
  logic [15:0] ifid_pc_plus1_q;
  logic        valid_q;
  logic [15:0] pc_inc_d;
  logic        is_halt_d;

  // 16-bit add wraps FFFF -> 0000 naturally.
  assign pc_inc_d  = pc_q + 16'd1;
  assign is_halt_d = (imem_instr[15:12] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      pc_q            <= RESET_PC;
      instr_q         <= NOP_INSTR;
      ifid_pc_q       <= 16'h0000;
      ifid_pc_plus1_q <= 16'h0000;
      valid_q         <= 1'b0;
    end else if (redirect) begin
      // Redirect beats stall; the younger fetch is squashed into a bubble.
      state_q <= RUN;
      pc_q    <= redirect_pc;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        RUN: begin
          instr_q         <= imem_instr;
          ifid_pc_q       <= pc_q;
          ifid_pc_plus1_q <= pc_inc_d;
          valid_q         <= 1'b1;
          if (is_halt_d) state_q <= HALTED;
          else           pc_q    <= pc_inc_d;
        end
        HALTED: begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign imem_pc       = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus1 = ifid_pc_plus1_q;
  assign ifid_valid    = valid_q;
  assign halted        = (state_q == HALTED);

endmodule
